// File: rtl/bcd_sub_if.sv
// Handshake and operand/result bundle for bcd_serial_subtractor.
// master drives start/a/b; slave (the subtractor) drives the status and result.
interface bcd_sub_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  borrow_out;
  logic                  invalid;

  modport master (
    output start, a, b,
    input  busy, done, result, borrow_out, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, borrow_out, invalid
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: result = a - b, one decimal digit per clock,
// LSD first, ten's complement plus borrow_out when a < b.
// Optional macro BCD_SUB_CHECK_EN: flag non-BCD input nibbles at capture and
// report invalid (with result and borrow_out forced to 0) in the done cycle.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic      clk,
  input  logic      rst,
  bcd_sub_if.slave  bus
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int W  = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic [CW-1:0]   cnt_q;
  logic            borrow_q;
  logic            borrow_out_q;
  logic            busy_q;
  logic            done_q;

  logic [5:0]      diff_d;
  logic [5:0]      corr_d;
  logic [3:0]      digit_d;
  logic            borrow_d;
  logic            last_d;

`ifdef BCD_SUB_CHECK_EN
  logic            bad_q;
  logic            invalid_q;

  // True when any nibble of v exceeds 9.
  function automatic logic has_nonbcd(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction
`endif

  // Current digit: signed difference, +10 correction and next borrow.
  always_comb begin
    diff_d   = {2'b00, a_q[3:0]} - {2'b00, b_q[3:0]} - {5'b0, borrow_q};
    corr_d   = diff_d;
    borrow_d = 1'b0;
    if (diff_d[5]) begin
      corr_d   = diff_d + 6'd10;
      borrow_d = 1'b1;
    end
    digit_d = corr_d[3:0];
    last_d  = (cnt_q == CW'(DIGITS - 1));
  end

  // Control FSM with registered outputs; operands shift right one digit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
      bad_q        <= 1'b0;
      invalid_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q          <= bus.a;
            b_q          <= bus.b;
            result_q     <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b1;
`ifdef BCD_SUB_CHECK_EN
            bad_q        <= has_nonbcd(bus.a) | has_nonbcd(bus.b);
            invalid_q    <= 1'b0;
`endif
            state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          result_q[4*cnt_q +: 4] <= digit_d;
          a_q      <= a_q >> 4;
          b_q      <= b_q >> 4;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_d) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            borrow_out_q <= borrow_d;
            state_q      <= S_DONE;
`ifdef BCD_SUB_CHECK_EN
            // Non-BCD operands: run full latency, then report a zeroed result.
            if (bad_q) begin
              result_q     <= '0;
              borrow_out_q <= 1'b0;
              invalid_q    <= 1'b1;
            end
`endif
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.borrow_out = borrow_out_q;
`ifdef BCD_SUB_CHECK_EN
  assign bus.invalid    = invalid_q;
`else
  assign bus.invalid    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed, table-driven bench for bcd_serial_subtractor (DIGITS=4).
module tb_bcd_serial_subtractor;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bcd_sub_if #(.DIGITS(4)) bif ();

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        bo;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One full operation: pulse start, scramble inputs after capture, then
  // check latency, busy length, outputs in the done cycle and hold after it.
  task automatic do_op(input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] er, input logic eb, input logic ei,
                       input string nm);
    int lat;
    int bcnt;
    bit seen;
    @(negedge clk);
    bif.a = va; bif.b = vb; bif.start = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    bif.a = va ^ 16'h9999;
    bif.b = 16'h1111;
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (bif.busy) bcnt++;
      if (bif.done) begin seen = 1'b1; lat = i; end
    end
    chk({nm, " latency"}, lat, 5);
    chk({nm, " busy_cycles"}, bcnt, 4);
    chk({nm, " result"}, {16'h0, bif.result}, {16'h0, er});
    chk({nm, " borrow_out"}, {31'h0, bif.borrow_out}, {31'h0, eb});
    chk({nm, " invalid"}, {31'h0, bif.invalid}, {31'h0, ei});
    @(negedge clk);
    chk({nm, " done_cleared"}, {31'h0, bif.done}, 32'h0);
    chk({nm, " result_held"}, {16'h0, bif.result}, {16'h0, er});
  endtask

  vec_t vecs[6];
  int   done_at[$];

  initial begin
    checks = 0; failures = 0;
    vecs[0] = '{16'h1234, 16'h0567, 16'h0667, 1'b0, "v1234_0567"};
    vecs[1] = '{16'h0100, 16'h0001, 16'h0099, 1'b0, "v0100_0001"};
    vecs[2] = '{16'h0003, 16'h0005, 16'h9998, 1'b1, "v0003_0005"};
    vecs[3] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, "v9999_9999"};
    vecs[4] = '{16'h0000, 16'h0001, 16'h9999, 1'b1, "v0000_0001"};
    vecs[5] = '{16'h5000, 16'h4999, 16'h0001, 1'b0, "v5000_4999"};

    rst = 1'b1; bif.start = 1'b0; bif.a = '0; bif.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'h0, bif.busy}, 32'h0);
    chk("reset done", {31'h0, bif.done}, 32'h0);
    chk("reset result", {16'h0, bif.result}, 32'h0);
    chk("reset borrow_out", {31'h0, bif.borrow_out}, 32'h0);
    chk("reset invalid", {31'h0, bif.invalid}, 32'h0);

    // rst and start together: reset wins, nothing launches.
    bif.start = 1'b1; bif.a = 16'h1234; bif.b = 16'h0567;
    @(negedge clk);
    chk("rst_start busy", {31'h0, bif.busy}, 32'h0);
    rst = 1'b0; bif.start = 1'b0;

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].bo, 1'b0, vecs[i].nm);

    // Start held high: one op accepted every 6 cycles, later starts ignored.
    @(negedge clk);
    bif.a = 16'h1234; bif.b = 16'h0567; bif.start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bif.done) begin
        done_at.push_back(i);
        chk("b2b result", {16'h0, bif.result}, 32'h0667);
      end
    end
    bif.start = 1'b0;
    chk("b2b done_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      chk("b2b first_done", done_at[0], 5);
      chk("b2b gap1", done_at[1] - done_at[0], 6);
      chk("b2b gap2", done_at[2] - done_at[1], 6);
    end
    repeat (8) @(negedge clk);

    // Reset during the 2nd RUN cycle abandons the operation.
    @(negedge clk);
    bif.a = 16'h1234; bif.b = 16'h0567; bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst busy", {31'h0, bif.busy}, 32'h0);
    chk("midrst done", {31'h0, bif.done}, 32'h0);
    chk("midrst result", {16'h0, bif.result}, 32'h0);
    chk("midrst borrow_out", {31'h0, bif.borrow_out}, 32'h0);
    begin
      int spurious;
      spurious = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bif.done || bif.busy) spurious++;
      end
      chk("midrst no_done", spurious, 0);
    end
    do_op(16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, "after_rst");

    // Non-BCD nibble in the minuend.
`ifdef BCD_SUB_CHECK_EN
    do_op(16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, "nonbcd");
`else
    do_op(16'h00A0, 16'h0001, 16'h0099, 1'b0, 1'b0, "nonbcd");
`endif
    // A following valid op clears invalid.
    do_op(16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0, "post_nonbcd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_serial_subtractor.md
# bcd_serial_subtractor

Multi-digit BCD subtractor computing A − B one decimal digit per clock, least-significant digit first, with a digit-to-digit borrow chain. It is the inverse of the per-digit mod-10 BCD adder and sits beside it in the decimal arithmetic datapath. A start/busy/done handshake launches each operation; the result is held until the next operation begins. Negative differences are returned as ten's complement with a borrow flag.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1)

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  launch request, sampled only in IDLE
- a  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0]
- b  input  4*DIGITS  subtrahend, packed BCD, same packing
- busy  output  1  high while digits are being processed (RUN)
- done  output  1  one-cycle pulse when result becomes valid
- result  output  4*DIGITS  packed BCD difference, held after done
- borrow_out  output  1  final borrow; 1 means a < b and result is the ten's complement
- invalid  output  1  input digit > 9 detected (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture a and b into internal shift registers, clear borrow, clear digit counter, clear result register, go to RUN. start=0 → stay.
- RUN: each cycle process digit k (k = 0..DIGITS−1):
  - diff = a_k − b_k − borrow, signed 6-bit.
  - diff < 0 → digit = diff + 10, next borrow = 1; else digit = diff, next borrow = 0.
  - Digit written to result position k (low 4 bits of the corrected value). Counter increments.
  - After digit DIGITS−1: go to DONE.
- DONE: done=1 for exactly one cycle; borrow_out = final borrow; go to IDLE.
- start while in RUN or DONE is ignored; no queuing.
- a and b may change freely after the capture edge.
- result, borrow_out, invalid are held stable from done until the next accepted start, at which point they are cleared.
- Arithmetic: no decimal overflow is possible; borrow_out is the only out-of-range indication.

## Timing
- Reset (rst=1 at rising edge): state IDLE; busy=0, done=0, result=0, borrow_out=0, invalid=0. Reset applies mid-operation; the operation is abandoned and produces no done.
- Start accepted at edge T0 → busy=1 for cycles T0+1 … T0+DIGITS → done=1 and busy=0 in cycle T0+DIGITS+1.
- Latency start→done: DIGITS+1 cycles. Minimum start-to-start spacing: DIGITS+2 cycles (start may be reasserted the first cycle back in IDLE).
- Digit k of result updates at the end of RUN cycle k; the full result is valid only in and after the done cycle.
- rst and start asserted together: rst wins.

## Configuration
- BCD_SUB_CHECK_EN defined: at capture, any nibble of a or b > 9 sets an internal flag. The operation runs for full latency; in the DONE cycle, invalid=1, result forced to 0, and borrow_out forced to 0. invalid is held like result.
- BCD_SUB_CHECK_EN undefined: no check; invalid is tied to 0. Non-BCD nibbles pass through the same per-digit formula, with the digit result truncated to 4 bits; the outcome is deterministic but not meaningful.

## Test plan
- DIGITS=4, a=1234, b=0567, start → done after 5 cycles; result=0667, borrow_out=0, busy high for 4 cycles.
- a=0100, b=0001 → result=0099 with borrow propagating across two digits, borrow_out=0.
- a=0003, b=0005 → result=9998, borrow_out=1; a=9999, b=9999 → result=0000, borrow_out=0.
- Back-to-back: start held continuously → operations accepted exactly every 6 cycles; starts during RUN/DONE are ignored; inputs changed mid-RUN do not affect the result.
- Reset asserted in the 2nd RUN cycle → next cycle is IDLE with all outputs 0 and no done pulse; a new start then completes normally.
- With BCD_SUB_CHECK_EN: a=00A0, b=0001 → done at normal latency, invalid=1, result=0000, borrow_out=0. Without the macro: invalid stays 0.
